// File: rtl/stream_in.sv
// stream_in: input-stream source node feeding the `up` port of one top-row core.
// The host loads 11-bit two's-complement words into a DEPTH-entry circular FIFO.
// The oldest word is moved into a registered head stage (up, head_valid).
// The head is presented to the core through the rready/read handshake.
//
// Build option:
//   STREAM_IN_CLAMP_EN - when defined, host words are saturated to [-999, 999]
//                        before storage; when undefined they are stored as-is.

module stream_in #(
  parameter int DEPTH  = 16,  // FIFO entries, power of two, excluding the head stage
  parameter int ADDR_W = 4    // log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,       // asynchronous, active-high
  // host side
  input  logic              wr_en,
  input  logic [10:0]       wr_data,
  output logic              full,
  output logic [ADDR_W+1:0] level,
  output logic              ovf,
  // core side
  input  logic              run,
  output logic [10:0]       up,
  output logic              rready,
  input  logic              read,
  output logic [15:0]       consumed
);

  // The count width can represent DEPTH itself.
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

`ifdef STREAM_IN_CLAMP_EN
  localparam logic signed [10:0] CLAMP_HI = 11'sd999;
  localparam logic signed [10:0] CLAMP_LO = -11'sd999;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [10:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [10:0]       r_up;
  logic              r_head_valid;
  logic              r_ovf;
  logic [15:0]       r_consumed;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic [10:0] w_wr_value;   // host word after optional saturation
  logic        w_full;       // FIFO (not counting the head) holds DEPTH words
  logic        w_push;       // host word accepted into the FIFO this edge
  logic        w_consume;    // core takes the head this edge
  logic        w_head_free;  // head stage can accept a new word this edge
  logic        w_pop;        // FIFO entry moves into the head stage this edge

  // Saturate the host word to the core value range when the clamp is built in.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default on its first
    // line, so no path through the block can leave it unassigned and infer a latch.
    w_wr_value = wr_data;
`ifdef STREAM_IN_CLAMP_EN
    if ($signed(wr_data) > CLAMP_HI) begin
      w_wr_value = CLAMP_HI;
    end else if ($signed(wr_data) < CLAMP_LO) begin
      w_wr_value = CLAMP_LO;
    end
`endif
  end

  // `full` comes from the registered count alone. A write landing on the same
  // edge as a pop from a full FIFO is therefore still rejected.
  assign w_full      = (r_count == DEPTH_CNT);
  assign w_push      = wr_en && !w_full;
  assign rready      = r_head_valid && run;
  assign w_consume   = read && rready;
  assign w_head_free = !r_head_valid || w_consume;
  assign w_pop       = (r_count != '0) && w_head_free;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------

  // Write accepted host words into the circular buffer.
  // NOTE: the array has no reset. Cleared pointers and count make stale contents
  // unreachable, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_value;
    end
  end

  // Advance the pointers and track occupancy. Pointers wrap naturally because DEPTH is 2**ADDR_W.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in the block samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head stage
  // ---------------------------------------------------------------------------

  // Refill the head from the FIFO whenever it is free, even while run=0.
  // Drop head_valid when the head is consumed and nothing is waiting behind it.
  // `up` keeps its last value when the head empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up         <= '0;
      r_head_valid <= 1'b0;
    end else if (w_pop) begin
      r_up         <= r_mem[r_rd_ptr];
      r_head_valid <= 1'b1;
    end else if (w_consume) begin
      r_head_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------

  // Set the sticky overflow flag on any write that arrives while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (wr_en && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  // Count words taken by the core. The counter wraps 0xFFFF -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_consumed <= '0;
    end else if (w_consume) begin
      r_consumed <= r_consumed + 16'd1;
    end
  end

  assign full     = w_full;
  assign level    = {1'b0, r_count} + (ADDR_W+2)'(r_head_valid);
  assign ovf      = r_ovf;
  assign up       = r_up;
  assign consumed = r_consumed;

endmodule

// File: tb/tb_stream_in.sv
// tb_stream_in: self-checking bench for stream_in.
// A scoreboard queue holds every word the host has successfully written but the
// core has not yet consumed. Its size is the expected `level`, and its front is
// the expected `up` whenever the core consumes.
// Scenario tasks run in sequence and add directed timing and boundary checks.

module tb_stream_in;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [10:0]       wr_data = '0;
  logic              run = 1'b0;
  logic              read = 1'b0;
  logic              full;
  logic [ADDR_W+1:0] level;
  logic              ovf;
  logic [10:0]       up;
  logic              rready;
  logic [15:0]       consumed;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [10:0] sb_q[$];
  logic [15:0] exp_consumed = '0;
  logic        exp_ovf = 1'b0;

  stream_in #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .level    (level),
    .ovf      (ovf),
    .run      (run),
    .up       (up),
    .rready   (rready),
    .read     (read),
    .consumed (consumed)
  );

  always #5 clk = ~clk;

  // Value the block is expected to store for a given host word.
  function automatic logic [10:0] model_store(input logic [10:0] v);
    logic signed [10:0] s;
    s = v;
`ifdef STREAM_IN_CLAMP_EN
    if (s > 11'sd999)  return 11'sd999;
    if (s < -11'sd999) return -11'sd999;
`endif
    return logic'(s) ? v : v;
  endfunction

  // Scoreboard monitor. At each falling edge it first checks the state left by
  // the last rising edge. It then applies the next rising edge's effects to the model.
  always @(negedge clk) begin
    bit accept;
    bit take;
    if (rst) begin
      sb_q.delete();
      exp_consumed = '0;
      exp_ovf      = 1'b0;
    end else if (mon_en) begin
      n_vec++;
      if (level !== 6'(sb_q.size())) begin
        n_err++;
        $display("FAIL level: got %0d expected %0d", level, sb_q.size());
      end
      n_vec++;
      if (full !== (sb_q.size() == DEPTH + 1)) begin
        n_err++;
        $display("FAIL full: got %b expected %b", full, sb_q.size() == DEPTH + 1);
      end
      n_vec++;
      if (ovf !== exp_ovf) begin
        n_err++;
        $display("FAIL ovf: got %b expected %b", ovf, exp_ovf);
      end
      n_vec++;
      if (consumed !== exp_consumed) begin
        n_err++;
        $display("FAIL consumed: got %0d expected %0d", consumed, exp_consumed);
      end
      // With two or more words held, the head must be valid. With none, it must not be.
      if (sb_q.size() != 1) begin
        n_vec++;
        if (rready !== (run && sb_q.size() >= 2)) begin
          n_err++;
          $display("FAIL rready: got %b expected %b (held %0d)", rready,
                   run && sb_q.size() >= 2, sb_q.size());
        end
      end
      accept = wr_en && (sb_q.size() <= DEPTH);
      if (wr_en && !accept) exp_ovf = 1'b1;
      take = read && (rready === 1'b1);
      if (take) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL data: got %h expected nothing (scoreboard empty)", up);
        end else begin
          if (up !== sb_q[0]) begin
            n_err++;
            $display("FAIL data: got %h expected %h", up, sb_q[0]);
          end
          void'(sb_q.pop_front());
        end
        exp_consumed = exp_consumed + 16'd1;
      end
      if (accept) sb_q.push_back(model_store(wr_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    read  = 1'b0;
    run   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [10:0] v);
    wr_data = v;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (level == '0 && rready == 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s drain timeout: level %0d after %0d cycles, expected 0", name, level, max_cycles);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_vec++;
    if ({up, rready, full, level, ovf, consumed} !== '0) begin
      n_err++;
      $display("FAIL %s: got up=%h rready=%b full=%b level=%0d ovf=%b consumed=%0d expected all 0",
               name, up, rready, full, level, ovf, consumed);
    end
  endtask

  task automatic test_reset();
    #1;
    check_zero_outputs("reset_asserted");
    apply_reset();
    mon_en = 1'b1;
    tick();
    check_zero_outputs("reset_released");
  endtask

  task automatic test_basic();
    apply_reset();
    run  = 1'b1;
    read = 1'b1;
    wr_data = 11'd5;  wr_en = 1'b1; tick();
    n_vec++;
    if (rready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_latency1: rready got %b expected 0", rready);
    end
    wr_data = 11'd7;  tick();
    n_vec++;
    if (rready !== 1'b1 || up !== 11'd5) begin
      n_err++;
      $display("FAIL basic_latency2: rready=%b up=%h expected 1 and 005", rready, up);
    end
    wr_data = -11'sd3; tick();
    wr_en = 1'b0;
    tick();
    tick();
    tick();
    n_vec++;
    if (consumed !== 16'd3 || rready !== 1'b0 || level !== '0 || up !== 11'h7FD) begin
      n_err++;
      $display("FAIL basic_end: consumed=%0d rready=%b level=%0d up=%h expected 3 0 0 7fd",
               consumed, rready, level, up);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      write_word(11'(100 + i));
      if (i == DEPTH - 1) begin
        n_vec++;
        if (full !== 1'b0 || level !== 6'd16) begin
          n_err++;
          $display("FAIL ovf_almost: full=%b level=%0d expected 0 16", full, level);
        end
      end
    end
    n_vec++;
    if (full !== 1'b1 || level !== 6'd17 || ovf !== 1'b0 || rready !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_full: full=%b level=%0d ovf=%b rready=%b expected 1 17 0 0",
               full, level, ovf, rready);
    end
    write_word(11'd600);
    n_vec++;
    if (ovf !== 1'b1 || level !== 6'd17) begin
      n_err++;
      $display("FAIL ovf_drop: ovf=%b level=%0d expected 1 17", ovf, level);
    end
    // Write collides with the first pop while full: must still be rejected.
    run  = 1'b1;
    read = 1'b1;
    write_word(11'd555);
    wait_drain(40, "ovf");
    n_vec++;
    if (consumed !== 16'd17 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drain: consumed=%0d ovf=%b expected 17 1", consumed, ovf);
    end
  endtask

  task automatic test_empty_read();
    apply_reset();
    run  = 1'b1;
    read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (consumed !== '0 || rready !== 1'b0) begin
        n_err++;
        $display("FAIL empty_read: consumed=%0d rready=%b expected 0 0", consumed, rready);
      end
    end
    write_word(11'd42);
    tick();
    n_vec++;
    if (rready !== 1'b1 || up !== 11'd42) begin
      n_err++;
      $display("FAIL empty_present: rready=%b up=%h expected 1 02a", rready, up);
    end
    tick();
    tick();
    n_vec++;
    if (consumed !== 16'd1 || level !== '0) begin
      n_err++;
      $display("FAIL empty_once: consumed=%0d level=%0d expected 1 0", consumed, level);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    run  = 1'b1;
    read = 1'b1;
    wr_en = 1'b1;
    wr_data = 11'd100; tick();
    wr_data = 11'd200; tick();
    wr_data = 11'd300; tick();
    wr_en = 1'b0;
    n_vec++;
    if (consumed !== 16'd1 || up !== 11'd200) begin
      n_err++;
      $display("FAIL midrst_pre: consumed=%0d up=%h expected 1 0c8", consumed, up);
    end
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst_async");
    tick();
    rst = 1'b0;
    tick();
    write_word(11'd9);
    tick();
    n_vec++;
    if (rready !== 1'b1 || up !== 11'd9 || consumed !== '0) begin
      n_err++;
      $display("FAIL midrst_first: rready=%b up=%h consumed=%0d expected 1 009 0", rready, up, consumed);
    end
    tick();
    n_vec++;
    if (consumed !== 16'd1 || level !== '0) begin
      n_err++;
      $display("FAIL midrst_count: consumed=%0d level=%0d expected 1 0", consumed, level);
    end
  endtask

  task automatic test_clamp();
    logic [10:0] vals [5];
    vals[0] = 11'h3FF;      // 1023
    vals[1] = 11'h400;      // -1024
    vals[2] = 11'd999;
    vals[3] = -11'sd999;
    vals[4] = 11'd1000;
    apply_reset();
    for (int i = 0; i < 5; i++) write_word(vals[i]);
    tick();
    n_vec++;
    if (up !== model_store(vals[0]) || rready !== 1'b0 || level !== 6'd5) begin
      n_err++;
      $display("FAIL clamp_head: up=%h rready=%b level=%0d expected %h 0 5",
               up, rready, level, model_store(vals[0]));
    end
    run  = 1'b1;
    read = 1'b1;
    wait_drain(20, "clamp");
    n_vec++;
    if (consumed !== 16'd5) begin
      n_err++;
      $display("FAIL clamp_count: consumed=%0d expected 5", consumed);
    end
  endtask

  task automatic test_consumed_wrap();
    apply_reset();
    run  = 1'b1;
    read = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      wr_data = 11'(i);
      tick();
    end
    wr_en = 1'b0;
    wait_drain(20, "wrap_preload");
    n_vec++;
    if (consumed !== 16'hFFFF) begin
      n_err++;
      $display("FAIL wrap_preload: consumed=%h expected ffff", consumed);
    end
    write_word(11'd77);
    wait_drain(20, "wrap_last");
    n_vec++;
    if (consumed !== 16'h0000 || ovf !== 1'b0 || full !== 1'b0 || level !== '0 || up !== 11'd77) begin
      n_err++;
      $display("FAIL wrap: consumed=%h ovf=%b full=%b level=%0d up=%h expected 0000 0 0 0 04d",
               consumed, ovf, full, level, up);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_read();
    test_mid_reset();
    test_clamp();
    test_consumed_wrap();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stream_in.md
Name: stream_in

Overview:
- Input-stream source node that feeds the `up` port of one core in the top row of the core array.
- The host/test harness loads a sequence of 11-bit values into an internal FIFO.
- The block presents the FIFO head to the core using the core-read handshake: the source drives data plus `rready`, and the core pulses `read` to consume.
- One instance per top-row column.

Parameters:
- DEPTH, 16, FIFO entries (power of two, >=2), excluding the head register.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  host write strobe
- wr_data  in  11  host value, two's complement
- full  out  1  FIFO holds DEPTH entries
- level  out  ADDR_W+2  FIFO count + head_valid
- ovf  out  1  sticky: write attempted while full
- run  in  1  stream enable toward core
- up  out  11  head value to core
- rready  out  1  head valid and run
- read  in  1  core consume strobe
- consumed  out  16  words consumed by core

Behaviour:
- Reset (async, rst=1):
  - head_valid=0, up=0, rready=0, full=0, level=0, ovf=0, consumed=0.
  - FIFO pointers and count cleared; contents discarded.
  - Applies mid-stream too; after release the block behaves as empty.
- Storage: DEPTH-entry circular FIFO (wr_ptr, rd_ptr, count of ADDR_W+1 bits) plus one registered head stage (up, head_valid).
- Write: if wr_en && !full at edge, the value is stored at wr_ptr; wr_ptr and count increment. Pointers wrap DEPTH-1 -> 0.
- Overflow: if wr_en && full, the write is dropped and ovf is set to 1 (stays 1 until reset).
- Simultaneous write and pop when full: the write is still rejected. `full` is evaluated from the registered count only.
- Head load: at an edge where the FIFO is non-empty and the head is free, up <= mem[rd_ptr], head_valid <= 1, and rd_ptr/count advance. The head is free when head_valid=0, or when read && rready in that cycle.
- No bypass: a write into an empty FIFO reaches `up` one edge later. Latency is 2 edges from the wr_en edge to rready=1.
- rready = head_valid & run (combinational from register and input).
  - Head loading continues while run=0; only presentation is gated.
- Consume:
  - read && rready at an edge consumes the head and increments `consumed`.
  - `consumed` wraps 0xFFFF -> 0.
  - If the FIFO is empty at that edge, head_valid <= 0.
  - Back-to-back reads sustain 1 word/cycle while the FIFO is non-empty.
- read while rready=0 is ignored: no state change, no counting.
- up holds its last value when head_valid drops. Consumers qualify it with rready.
- level = count + head_valid, updated every edge; maximum DEPTH+1.

Optional Feature:
- Macro: STREAM_IN_CLAMP_EN.
- Defined: wr_data is saturated before storage to the core value range.
  - Values > 999 are stored as 999.
  - Values < -999 are stored as -999.
  - Comparison is signed on 11 bits.
- Undefined: wr_data is stored unchanged. Any 11-bit pattern reaches `up`.

Test Plan:
- Reset, write 5, 7, -3 with run=1, read held 1 -> rready rises 2 edges after first write; up presents 5, 7, -3 on consecutive cycles; consumed=3; rready=0 afterward; level=0.
- run=0, write DEPTH+1=17 values, then one more -> full=1 after 17 writes (16 FIFO + head); level=17; 18th write dropped; ovf=1. Then run=1 with continuous reads -> exactly 17 values delivered in order, wrapping pointers.
- Read asserted with FIFO empty for 10 cycles, then write 42 -> consumed stays 0 until 42 appears; 42 consumed exactly once.
- Stream 100, 200, 300; pulse rst mid-stream after 100 is consumed -> all outputs 0 immediately (async); subsequent write 9 is delivered as the first value; consumed counts from 0.
- With STREAM_IN_CLAMP_EN: write 1023 and -1024 -> up shows 999 and -999. Without the macro -> up shows 1023 and -1024 unchanged.
- Preload consumed to 0xFFFF via 65535 reads, then one more read -> consumed=0; no other state disturbed.
